// File: rtl/cache_miss_engine.sv
// Cache miss engine: optional dirty-victim writeback, then block refill over the memory protocol.
// Optional statistics counters are enabled by defining MISS_ENGINE_STATS_EN.

package cache_structs_def;
    localparam int unsigned ADDR_WIDTH   = 32;
    localparam int unsigned BLOCK_SIZE   = 16;
    localparam int unsigned OFFSET_WIDTH = $clog2(BLOCK_SIZE);

    typedef struct packed {
        logic                    cs;
        logic                    rw;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [BLOCK_SIZE*8-1:0] data;
    } memory_request_t;

    typedef struct packed {
        logic                    ack;
        logic [BLOCK_SIZE*8-1:0] data;
    } memory_response_t;
endpackage

module cache_miss_engine
    import cache_structs_def::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1023
`ifdef MISS_ENGINE_STATS_EN
    ,
    parameter int unsigned STAT_WIDTH  = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic                    req_wb,
    input  logic [ADDR_WIDTH-1:0]   wb_addr,
    input  logic [BLOCK_SIZE*8-1:0] wb_data,
    output logic                    fill_valid,
    output logic [ADDR_WIDTH-1:0]   fill_addr,
    output logic [BLOCK_SIZE*8-1:0] fill_data,
    output logic                    fill_err,
    output memory_request_t         mem_req,
    input  memory_response_t        mem_res
`ifdef MISS_ENGINE_STATS_EN
    ,
    output logic [STAT_WIDTH-1:0]   stat_miss,
    output logic [STAT_WIDTH-1:0]   stat_wb
`endif
);

    localparam int unsigned BlkW = BLOCK_SIZE * 8;
    localparam int unsigned CntW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [ADDR_WIDTH-1:0] AlignMask =
        ~((ADDR_WIDTH'(1) << OFFSET_WIDTH) - ADDR_WIDTH'(1));

    typedef enum logic [2:0] {StIdle, StWbReq, StWbGap, StRdReq, StRdGap, StFill} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] miss_addr_q, miss_addr_d;
    logic                  err_q, err_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    memory_request_t       mem_req_q, mem_req_d;
    logic [ADDR_WIDTH-1:0] fill_addr_q, fill_addr_d;
    logic [BlkW-1:0]       fill_data_q, fill_data_d;
    logic                  timeout;

    assign timeout = (cnt_q == CntW'(ACK_TIMEOUT - 1));

    // mem_req is loaded on the transition so cs rises the cycle after accept
    // and falls the cycle after ack is sampled.
    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        err_d       = err_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        fill_addr_d = fill_addr_q;
        fill_data_d = fill_data_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid) begin
                    miss_addr_d = req_addr & AlignMask;
                    err_d       = 1'b0;
                    cnt_d       = '0;
                    if (req_wb) begin
                        state_d   = StWbReq;
                        mem_req_d = '{cs: 1'b1, rw: 1'b1, addr: wb_addr & AlignMask, data: wb_data};
                    end else begin
                        state_d   = StRdReq;
                        mem_req_d = '{cs: 1'b1, rw: 1'b0, addr: req_addr & AlignMask, data: '0};
                    end
                end
            end
            StWbReq: begin
                if (mem_res.ack) begin
                    state_d      = StWbGap;
                    mem_req_d.cs = 1'b0;
                end else if (timeout) begin
                    state_d      = StFill;
                    err_d        = 1'b1;
                    mem_req_d.cs = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StWbGap: begin
                state_d   = StRdReq;
                cnt_d     = '0;
                mem_req_d = '{cs: 1'b1, rw: 1'b0, addr: miss_addr_q, data: '0};
            end
            StRdReq: begin
                if (mem_res.ack) begin
                    state_d      = StRdGap;
                    mem_req_d.cs = 1'b0;
                    fill_addr_d  = miss_addr_q;
                    fill_data_d  = mem_res.data;
                end else if (timeout) begin
                    state_d      = StFill;
                    err_d        = 1'b1;
                    mem_req_d.cs = 1'b0;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StRdGap: state_d = StFill;
            StFill:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            miss_addr_q <= '0;
            err_q       <= 1'b0;
            cnt_q       <= '0;
            mem_req_q   <= '0;
            fill_addr_q <= '0;
            fill_data_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            err_q       <= err_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            fill_addr_q <= fill_addr_d;
            fill_data_q <= fill_data_d;
        end
    end

    assign req_ready  = (state_q == StIdle);
    assign fill_valid = (state_q == StFill);
    assign fill_err   = (state_q == StFill) && err_q;
    assign fill_addr  = fill_addr_q;
    assign fill_data  = fill_data_q;
    assign mem_req    = mem_req_q;

`ifdef MISS_ENGINE_STATS_EN
    logic [STAT_WIDTH-1:0] stat_miss_q, stat_wb_q;
    logic                  accept;

    assign accept = (state_q == StIdle) && req_valid;

    // Saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_miss_q <= '0;
            stat_wb_q   <= '0;
        end else if (accept) begin
            if (~&stat_miss_q) stat_miss_q <= stat_miss_q + STAT_WIDTH'(1);
            if (req_wb && ~&stat_wb_q) stat_wb_q <= stat_wb_q + STAT_WIDTH'(1);
        end
    end

    assign stat_miss = stat_miss_q;
    assign stat_wb   = stat_wb_q;
`endif

endmodule

// File: tb/tb_cache_miss_engine.sv
// Self-checking bench for cache_miss_engine: transfer-queue reference model, behavioural memory,
// directed protocol scenarios and randomized traffic.
module tb_cache_miss_engine;
    import cache_structs_def::*;

    localparam int unsigned TO = 16;
    localparam int unsigned BW = BLOCK_SIZE * 8;
    typedef logic [ADDR_WIDTH-1:0] addr_t;
    typedef logic [BW-1:0]         blk_t;
    localparam addr_t AMASK = ~addr_t'(BLOCK_SIZE - 1);

    typedef struct packed {
        logic  rw;
        addr_t addr;
        blk_t  data;
    } xfer_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req_valid = 1'b0;
    logic             req_wb = 1'b0;
    addr_t            req_addr = '0;
    addr_t            wb_addr = '0;
    blk_t             wb_data = '0;
    logic             req_ready, fill_valid, fill_err;
    addr_t            fill_addr;
    blk_t             fill_data;
    memory_request_t  mem_req;
    memory_response_t mem_res;
`ifdef MISS_ENGINE_STATS_EN
    logic [15:0]      stat_miss, stat_wb;
`endif

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int n_fill = 0;

    cache_miss_engine #(
        .ACK_TIMEOUT(TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_wb    (req_wb),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .fill_valid(fill_valid),
        .fill_addr (fill_addr),
        .fill_data (fill_data),
        .fill_err  (fill_err),
        .mem_req   (mem_req),
        .mem_res   (mem_res)
`ifdef MISS_ENGINE_STATS_EN
        ,
        .stat_miss (stat_miss),
        .stat_wb   (stat_wb)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, blk_t act, blk_t exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endfunction

    // ---------------- behavioural memory ----------------
    blk_t  mem [addr_t];
    bit    stall = 0;
    bit    rand_stall = 0;
    bit    cs_prev = 0;
    bit    done = 0;
    int    lat = 0;
    int    run = 0;
    int    last_run = 0;
    int    viol = 0;
    int    wr_ack_cyc = 0;
    int    rd_ack_cyc = 0;
    int    rd_rise_cyc = 0;
    addr_t log_wr_addr = '0;
    addr_t log_rd_addr = '0;

    function automatic blk_t preload(addr_t a);
        return {a, ~a, a ^ 32'h5a5a_a5a5, a + 32'h1357_9bdf};
    endfunction

    function automatic blk_t mem_rd(addr_t a);
        if (mem.exists(a)) return mem[a];
        return preload(a);
    endfunction

    initial begin
        mem_res = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_res.ack  = 1'b0;
            mem_res.data = blk_t'({$urandom, $urandom, $urandom, $urandom});
            if (mem_req.cs) begin
                if (!cs_prev) begin
                    run  = 0;
                    done = 0;
                    if (stall || (rand_stall && $urandom_range(0, 9) == 0)) lat = 100000;
                    else lat = int'($urandom_range(0, 3));
                    if (!mem_req.rw) rd_rise_cyc = cyc;
                end
                run++;
                if (done) viol++;
                else if (lat == 0) begin
                    mem_res.ack = 1'b1;
                    done        = 1;
                    if (mem_req.rw) begin
                        mem[mem_req.addr] = mem_req.data;
                        wr_ack_cyc        = cyc;
                        log_wr_addr       = mem_req.addr;
                    end else begin
                        mem_res.data = mem_rd(mem_req.addr);
                        rd_ack_cyc   = cyc;
                        log_rd_addr  = mem_req.addr;
                    end
                end else lat--;
            end else begin
                if (cs_prev) last_run = run;
                // Stray acks while cs is low must be ignored.
                if ($urandom_range(0, 3) == 0) mem_res.ack = 1'b1;
            end
            cs_prev = mem_req.cs;
        end
    end

    // ---------------- reference model ----------------
    logic  m_ready = 1'b1, m_cs = 1'b0, m_rw = 1'b0, m_fv = 1'b0, m_fe = 1'b0;
    addr_t m_addr = '0, m_fa = '0;
    blk_t  m_data = '0, m_fd = '0;
    int    m_since = 0;
    int    m_act = 0;  // 1: start next transfer, 2: deliver fill
    int    m_stat_miss = 0, m_stat_wb = 0;
    xfer_t xq[$];

    function automatic void load_next();
        xfer_t x;
        x       = xq.pop_front();
        m_cs    = 1'b1;
        m_rw    = x.rw;
        m_addr  = x.addr;
        m_data  = x.data;
        m_since = 0;
    endfunction

    function automatic void model_step();
        xfer_t x;
        logic  nfv;
        logic  nfe;
        nfv = 1'b0;
        nfe = 1'b0;
        if (rst) begin
            m_ready = 1'b1; m_cs = 1'b0; m_rw = 1'b0; m_addr = '0; m_data = '0;
            m_fa = '0; m_fd = '0; m_act = 0; m_fv = 1'b0; m_fe = 1'b0;
            m_stat_miss = 0; m_stat_wb = 0;
            xq.delete();
            return;
        end
        if (m_ready) begin
            if (req_valid) begin
                m_ready = 1'b0;
                if (req_wb) begin
                    x.rw = 1'b1; x.addr = wb_addr & AMASK; x.data = wb_data;
                    xq.push_back(x);
                end
                x.rw = 1'b0; x.addr = req_addr & AMASK; x.data = '0;
                xq.push_back(x);
                if (m_stat_miss < 16'hFFFF) m_stat_miss++;
                if (req_wb && m_stat_wb < 16'hFFFF) m_stat_wb++;
                load_next();
            end
        end else if (m_cs) begin
            if (mem_res.ack) begin
                m_cs = 1'b0;
                if (m_rw) m_act = 1;
                else begin
                    m_act = 2;
                    m_fa  = m_addr;
                    m_fd  = mem_res.data;
                end
            end else if (m_since + 1 == TO) begin
                m_cs = 1'b0;
                nfv  = 1'b1;
                nfe  = 1'b1;
                xq.delete();
            end else m_since++;
        end else if (m_fv) m_ready = 1'b1;
        else if (m_act == 1) begin
            load_next();
            m_act = 0;
        end else if (m_act == 2) begin
            nfv   = 1'b1;
            m_act = 0;
        end
        m_fv = nfv;
        m_fe = nfe;
    endfunction

    // Compare process: every negedge, DUT outputs against the model.
    initial begin
        forever begin
            @(negedge clk);
            check("req_ready", blk_t'(req_ready), blk_t'(m_ready));
            check("fill_valid", blk_t'(fill_valid), blk_t'(m_fv));
            if (m_fv) check("fill_err", blk_t'(fill_err), blk_t'(m_fe));
            check("mem_cs", blk_t'(mem_req.cs), blk_t'(m_cs));
            if (m_cs) begin
                check("mem_rw", blk_t'(mem_req.rw), blk_t'(m_rw));
                check("mem_addr", blk_t'(mem_req.addr), blk_t'(m_addr));
                check("mem_data", mem_req.data, m_data);
            end
            check("fill_addr", blk_t'(fill_addr), blk_t'(m_fa));
            check("fill_data", fill_data, m_fd);
`ifdef MISS_ENGINE_STATS_EN
            check("stat_miss", blk_t'(stat_miss), blk_t'(m_stat_miss));
            check("stat_wb", blk_t'(stat_wb), blk_t'(m_stat_wb));
`endif
            if (fill_valid) n_fill++;
            model_step();
        end
    end

    // ---------------- stimulus ----------------
    task automatic wait_accept();
        bit ok;
        ok = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (req_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic issue(addr_t a, logic wb, addr_t wa, blk_t wd);
        req_addr  = a;
        req_wb    = wb;
        wb_addr   = wa;
        wb_data   = wd;
        req_valid = 1'b1;
        wait_accept();
        req_valid = 1'b0;
    endtask

    task automatic wait_fill(output int fc, output logic fe);
        bit seen;
        seen = 0;
        fc   = -1;
        fe   = 1'bx;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (fill_valid) begin
                seen = 1;
                fc   = cyc;
                fe   = fill_err;
                break;
            end
        end
        if (!seen) check("fill_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int   fc;
        int   c0;
        int   rise0;
        logic fe;
        blk_t vict;
        vict = 128'hAFAEADACABAAA9A8A7A6A5A4A3A2A1A0;

        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", blk_t'(req_ready), 1);
        check("rst_cs", blk_t'(mem_req.cs), 0);
        check("rst_fill_data", fill_data, 0);
        @(posedge clk);
        #1;

        // Clean miss.
        issue(32'h1234, 1'b0, '0, '0);
        wait_fill(fc, fe);
        check("clean_rd_addr", blk_t'(log_rd_addr), blk_t'(32'h1230));
        check("clean_latency", blk_t'(fc - rd_ack_cyc), 2);
        check("clean_err", blk_t'(fe), 0);
        check("clean_fill_addr", blk_t'(fill_addr), blk_t'(32'h1230));
        check("clean_fill_data", fill_data, preload(32'h1230));

        // Dirty miss then readback of the victim.
        issue(32'h0800, 1'b1, 32'h0400, vict);
        wait_fill(fc, fe);
        check("dirty_wr_addr", blk_t'(log_wr_addr), blk_t'(32'h0400));
        check("dirty_gap", blk_t'(rd_rise_cyc - wr_ack_cyc), 2);
        check("dirty_rd_addr", blk_t'(log_rd_addr), blk_t'(32'h0800));
        issue(32'h0400, 1'b0, '0, '0);
        wait_fill(fc, fe);
        check("readback", fill_data, vict);

        // Back-to-back with req_valid held.
        req_wb    = 1'b0;
        req_addr  = 32'h2000;
        req_valid = 1'b1;
        wait_accept();
        c0       = n_fill;
        req_addr = 32'h3010;
        wait_accept();
        check("b2b_after_fill", blk_t'(n_fill - c0), 1);
        req_valid = 1'b0;
        wait_fill(fc, fe);

        // Read timeout.
        stall = 1;
        issue(32'h5550, 1'b0, '0, '0);
        wait_fill(fc, fe);
        check("to_err", blk_t'(fe), 1);
        check("to_cs_cycles", blk_t'(last_run), blk_t'(TO));
        @(negedge clk);
        check("to_idle", blk_t'(req_ready), 1);
        @(posedge clk);
        #1;

        // Writeback timeout: read must be skipped.
        rise0 = rd_rise_cyc;
        issue(32'h5560, 1'b1, 32'h5570, vict);
        wait_fill(fc, fe);
        check("wbto_err", blk_t'(fe), 1);
        check("wbto_no_read", blk_t'(rd_rise_cyc), blk_t'(rise0));

        // Reset mid read request.
        issue(32'h6660, 1'b0, '0, '0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_cs", blk_t'(mem_req.cs), 0);
        check("rst_mid_ready", blk_t'(req_ready), 1);
        c0 = n_fill;
        repeat (20) @(posedge clk);
        #1;
        check("rst_mid_no_fill", blk_t'(n_fill - c0), 0);
        stall = 0;
        issue(32'h7777, 1'b0, '0, '0);
        wait_fill(fc, fe);
        check("post_rst_err", blk_t'(fe), 0);
        check("post_rst_data", fill_data, mem_rd(32'h7770));

`ifdef MISS_ENGINE_STATS_EN
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            issue(addr_t'(32'h9000 + i * 16), 1'b0, '0, '0);
            wait_fill(fc, fe);
        end
        for (int i = 0; i < 2; i++) begin
            issue(addr_t'(32'hA000 + i * 16), 1'b1, addr_t'(32'hB000 + i * 16), vict);
            wait_fill(fc, fe);
        end
        check("stat_miss_5", blk_t'(stat_miss), 5);
        check("stat_wb_2", blk_t'(stat_wb), 2);
`endif

        // Randomized traffic with held req_valid, random latency and stalls.
        rand_stall = 1;
        req_valid  = 1'b1;
        for (int i = 0; i < 60; i++) begin
            req_addr = addr_t'($urandom_range(0, 32'h0000_0FFF));
            req_wb   = 1'($urandom_range(0, 1));
            wb_addr  = addr_t'($urandom);
            wb_data  = blk_t'({$urandom, $urandom, $urandom, $urandom});
            wait_accept();
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                repeat ($urandom_range(1, 5)) @(posedge clk);
                #1;
                req_valid = 1'b1;
            end
        end
        req_valid = 1'b0;
        wait_fill(fc, fe);
        repeat (5) @(posedge clk);
        #1;

        check("no_cs_after_ack", blk_t'(viol), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
